// File: rtl/pipeline_ctrl.sv
// SimpleRISC 5-stage pipeline sequencer: load-use interlock, branch flush, reset flush, halt/drain, debug step.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush event counters.
module pipeline_ctrl #(
    parameter int RST_FLUSH_CYCLES = 4,
    parameter int DRAIN_CYCLES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_OF,
    input  logic [4:0] rs2_OF,
    input  logic       use_rs1_OF,
    input  logic       use_rs2_OF,
    input  logic [4:0] rd_ALU,
    input  logic       isLd_ALU,
    input  logic       isWb_ALU,
    input  logic       isBranchTaken,
    input  logic       isHalt_OF,
    input  logic       step_req,
    input  logic       resume,
    output logic       stall_IF,
    output logic       stall_IFOF,
    output logic       bubble_OFALU,
    output logic       flush_IFOF,
    output logic       pc_sel_branch,
    output logic       halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        RSTFL  = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        HALTED = 3'd3,
        STEP   = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_step_q;
    logic       r_resume_flush;

    logic w_active;
    logic w_hold;
    logic w_rstfl;
    logic w_lu;
    logic w_br;
    logic w_ld_use;
    logic w_halt;
    logic w_step_rise;

    assign w_rstfl  = (r_state == RSTFL);
    assign w_active = (r_state == RUN) || (r_state == STEP);
    assign w_hold   = (r_state == DRAIN) || (r_state == HALTED);

    assign w_lu = isLd_ALU & isWb_ALU &
                  ((use_rs1_OF & (rs1_OF == rd_ALU)) |
                   (use_rs2_OF & (rs2_OF == rd_ALU)));

    // The OF instruction is wrong-path under a taken branch, so its hazards are moot
    assign w_br     = w_active & isBranchTaken;
    assign w_ld_use = w_active & ~isBranchTaken & w_lu;
    assign w_halt   = w_active & ~isBranchTaken & ~w_lu &
                      isHalt_OF & ~r_resume_flush;

    assign w_step_rise = step_req & ~r_step_q;

    // Halt cycle holds IF/OF so the halt instruction stays parked in OF
    assign stall_IF      = w_rstfl | w_hold | w_ld_use | w_halt;
    assign stall_IFOF    = w_hold | w_ld_use | w_halt;
    assign bubble_OFALU  = w_rstfl | w_hold | w_br | w_ld_use | w_halt;
    assign flush_IFOF    = w_rstfl | w_br |
                           ((r_state == RUN) & r_resume_flush);
    assign pc_sel_branch = w_br;
    assign halted        = (r_state == HALTED);
    assign state_dbg     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RSTFL;
            r_cnt          <= 4'(RST_FLUSH_CYCLES - 1);
            r_step_q       <= 1'b1;
            r_resume_flush <= 1'b0;
        end else begin
            r_step_q       <= step_req;
            r_resume_flush <= 1'b0;
            case (r_state)
                RSTFL: begin
                    if (r_cnt == 4'd0) r_state <= RUN;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                RUN, STEP: begin
                    if (w_halt) begin
                        r_state <= DRAIN;
                        r_cnt   <= 4'(DRAIN_CYCLES - 1);
                    end else if (r_state == STEP) begin
                        r_state <= HALTED;
                    end
                end
                DRAIN: begin
                    if (r_cnt == 4'd0) r_state <= HALTED;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                HALTED: begin
                    if (resume) begin
                        r_state        <= RUN;
                        r_resume_flush <= 1'b1;
                    end else if (w_step_rise) begin
                        r_state <= STEP;
                    end
                end
                default: r_state <= RSTFL;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_ld_use && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_br && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl.
// Perf-counter vectors are built only when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_OF, rs2_OF, rd_ALU;
    logic       use_rs1_OF, use_rs2_OF;
    logic       isLd_ALU, isWb_ALU, isBranchTaken, isHalt_OF;
    logic       step_req, resume;
    logic       stall_IF, stall_IFOF, bubble_OFALU, flush_IFOF;
    logic       pc_sel_branch, halted;
    logic [2:0] state_dbg;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_OF        (rs1_OF),
        .rs2_OF        (rs2_OF),
        .use_rs1_OF    (use_rs1_OF),
        .use_rs2_OF    (use_rs2_OF),
        .rd_ALU        (rd_ALU),
        .isLd_ALU      (isLd_ALU),
        .isWb_ALU      (isWb_ALU),
        .isBranchTaken (isBranchTaken),
        .isHalt_OF     (isHalt_OF),
        .step_req      (step_req),
        .resume        (resume),
        .stall_IF      (stall_IF),
        .stall_IFOF    (stall_IFOF),
        .bubble_OFALU  (bubble_OFALU),
        .flush_IFOF    (flush_IFOF),
        .pc_sel_branch (pc_sel_branch),
        .halted        (halted),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_OF = 5'd0; rs2_OF = 5'd0; rd_ALU = 5'd0;
        use_rs1_OF = 1'b0; use_rs2_OF = 1'b0;
        isLd_ALU = 1'b0; isWb_ALU = 1'b0;
        isBranchTaken = 1'b0; isHalt_OF = 1'b0;
        resume = 1'b0;
    endtask

    task automatic set_lu();
        isLd_ALU = 1'b1; isWb_ALU = 1'b1;
        rd_ALU = 5'd5; rs2_OF = 5'd5; use_rs2_OF = 1'b1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        chk({tag, ".ctrl"},
            {11'd0, stall_IF, stall_IFOF, bubble_OFALU, flush_IFOF,
             pc_sel_branch}, {11'd0, exp});
    endtask

    task automatic chk_rstfl(input string tag);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({tag, ".st"}, {13'd0, state_dbg}, 16'd0);
            chk_ctrl(tag, 5'b10110);
            chk({tag, ".halted"}, {15'd0, halted}, 16'd0);
            cyc();
        end
        #1;
        chk({tag, ".run"}, {13'd0, state_dbg}, 16'd1);
        chk_ctrl({tag, ".run"}, 5'b00000);
    endtask

    initial begin
        idle();
        step_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_rstfl("reset");

        // load-use via rs2
        set_lu();
        #1;
        chk_ctrl("lu_rs2", 5'b11100);
        cyc();
        use_rs2_OF = 1'b0;
        #1;
        chk_ctrl("lu_nouse", 5'b00000);
        chk("lu_nouse.st", {13'd0, state_dbg}, 16'd1);
        cyc();
        // r0 is an ordinary register
        idle();
        isLd_ALU = 1'b1; isWb_ALU = 1'b1; use_rs1_OF = 1'b1;
        #1;
        chk_ctrl("lu_r0", 5'b11100);
        cyc();
        isWb_ALU = 1'b0;
        #1;
        chk_ctrl("lu_nowb", 5'b00000);
        cyc();

        // branch beats load-use and halt
        idle();
        set_lu();
        isBranchTaken = 1'b1;
        isHalt_OF = 1'b1;
        #1;
        chk_ctrl("br_lu", 5'b00111);
        cyc();
        idle();
        #1;
        chk("br_nohalt.st", {13'd0, state_dbg}, 16'd1);
        cyc();

        // halt, drain, step, resume
        isHalt_OF = 1'b1;
        cyc();
        isHalt_OF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain.st", {13'd0, state_dbg}, 16'd2);
            chk_ctrl("drain", 5'b11100);
            chk("drain.halted", {15'd0, halted}, 16'd0);
            cyc();
        end
        #1;
        chk("halted.st", {13'd0, state_dbg}, 16'd3);
        chk("halted.halted", {15'd0, halted}, 16'd1);
        chk_ctrl("halted", 5'b11100);
        cyc();
        step_req = 1'b1;
        #1;
        chk("step_pre.st", {13'd0, state_dbg}, 16'd3);
        cyc();
        #1;
        chk("step.st", {13'd0, state_dbg}, 16'd4);
        chk_ctrl("step", 5'b00000);
        chk("step.halted", {15'd0, halted}, 16'd0);
        cyc();
        #1;
        chk("step_back.st", {13'd0, state_dbg}, 16'd3);
        cyc();
        #1;
        chk("step_level.st", {13'd0, state_dbg}, 16'd3);
        step_req = 1'b0;
        cyc();
        // resume wins over a simultaneous step edge
        resume = 1'b1;
        step_req = 1'b1;
        cyc();
        resume = 1'b0;
        step_req = 1'b0;
        #1;
        chk("resume.st", {13'd0, state_dbg}, 16'd1);
        chk_ctrl("resume", 5'b00010);
        cyc();
        #1;
        chk_ctrl("resume2", 5'b00000);
        chk("resume2.st", {13'd0, state_dbg}, 16'd1);
        cyc();

        // reset during drain
        isHalt_OF = 1'b1;
        cyc();
        isHalt_OF = 1'b0;
        cyc();
        #1;
        chk("drain2.st", {13'd0, state_dbg}, 16'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_rstfl("rst_drain");

`ifdef PIPE_CTRL_PERF_EN
        chk("perf.stall0", stall_cnt, 16'd0);
        chk("perf.flush0", flush_cnt, 16'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            set_lu();
            cyc();
            idle();
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            isBranchTaken = 1'b1;
            cyc();
            isBranchTaken = 1'b0;
            cyc();
        end
        #1;
        chk("perf.stall3", stall_cnt, 16'd3);
        chk("perf.flush2", flush_cnt, 16'd2);
        set_lu();
        for (int i = 0; i < 65533; i++) cyc();
        #1;
        chk("perf.stall_max", stall_cnt, 16'hFFFF);
        cyc();
        #1;
        chk("perf.stall_sat", stall_cnt, 16'hFFFF);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencer for the 5-stage SimpleRISC core (IF, OF, ALU, DM, WB). It detects load-use hazards and inserts one-cycle interlocks, and it flushes wrong-path instructions when a branch resolves taken in the ALU stage. It also sequences post-reset pipeline clearing and halt/drain, and provides a debug single-step mode. It sits beside the pipe registers and drives their hold and bubble controls; data forwarding stays in the existing forwarding unit.

## Interface
- RST_FLUSH_CYCLES, default 4: cycles of forced bubbles after reset release (range 1–15).
- DRAIN_CYCLES, default 3: cycles allowed for older instructions to retire after a halt is decoded (range 1–7).
- clk  in  1  pipeline clock (the divided core clock).
- rst  in  1  reset; one clock, synchronous, active-high.
- rs1_OF, rs2_OF  in  5 each  source registers of the instruction in OF.
- use_rs1_OF, use_rs2_OF  in  1 each  OF instruction reads that source.
- rd_ALU  in  5  destination register of the instruction in ALU.
- isLd_ALU, isWb_ALU  in  1 each  ALU-stage instruction is a load / writes back.
- isBranchTaken  in  1  taken branch resolved in ALU this cycle.
- isHalt_OF  in  1  OF holds a halt instruction.
- step_req  in  1  debug: advance one cycle while halted (level, edge-detected internally).
- resume  in  1  debug: leave HALTED.
- stall_IF  out  1  hold PC.
- stall_IFOF  out  1  hold IF/OF register.
- bubble_OFALU  out  1  load a NOP (isWb=0, isLd=isSt=0) into OF/ALU.
- flush_IFOF  out  1  load a NOP into IF/OF.
- pc_sel_branch  out  1  PC takes branchPC next edge.
- halted  out  1  core is in HALTED.
- state_dbg  out  3  current FSM state encoding.

## Operation
- FSM states: RSTFL=0, RUN=1, DRAIN=2, HALTED=3, STEP=4.
- RSTFL: stall_IF=1, flush_IFOF=1, bubble_OFALU=1. A 4-bit counter loads RST_FLUSH_CYCLES-1 on rst and decrements each cycle. When the counter reaches 0, go to RUN.
- RUN, load-use: lu = isLd_ALU & isWb_ALU & ((use_rs1_OF & rs1_OF==rd_ALU) | (use_rs2_OF & rs2_OF==rd_ALU)). r0 is a normal register, so there is no zero exclusion. lu asserts stall_IF, stall_IFOF and bubble_OFALU for that cycle only.
- RUN, branch: isBranchTaken asserts pc_sel_branch, flush_IFOF and bubble_OFALU. It does not assert stall_IF.
- Priority: isBranchTaken > lu > halt. When a branch is taken, lu and isHalt_OF are ignored, because the OF instruction is wrong-path.
- RUN, halt: isHalt_OF with no branch and no lu moves the FSM to DRAIN and loads the drain counter with DRAIN_CYCLES-1.
- DRAIN: stall_IF=1, stall_IFOF=1, bubble_OFALU=1 every cycle. At counter 0, go to HALTED.
- HALTED: same outputs as DRAIN, plus halted=1.
  - A rising edge of step_req moves the FSM to STEP.
  - resume=1 moves the FSM to RUN. resume takes priority over step_req.
- STEP: behaves exactly as RUN for one cycle, including load-use, branch and halt handling. It then returns to HALTED, or to DRAIN if it saw a halt.
- On a halt instruction the IF/OF register is held, so the halt stays in OF. After resume, that halt is retired by forcing flush_IFOF=1 in the first RUN cycle.

## Timing
- All hazard outputs are combinational from the inputs and the registered state, and take effect at the next clk edge. The load-use interlock costs exactly 1 cycle.
- A taken branch costs 2 cycles: the IF/OF and OF/ALU contents are discarded.
- Reset values (the cycle after rst): state=RSTFL, stall_IF=flush_IFOF=bubble_OFALU=1, pc_sel_branch=0, halted=0, state_dbg=0.
- rst asserted in any state returns the FSM to RSTFL on the next edge and reloads the counter.
- Halt latency: first DRAIN cycle is the edge after isHalt_OF; halted=1 at DRAIN_CYCLES+1 edges after that.
- The step_req edge detector register resets to 1, so a step_req already held high at reset does not trigger a step.

## Configuration
- PIPE_CTRL_PERF_EN is defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each lu cycle; flush_cnt increments on each taken-branch cycle.
  - Both counters saturate at 0xFFFF, clear on rst, and do not count in RSTFL, DRAIN or HALTED.
- PIPE_CTRL_PERF_EN is not defined: the ports and registers are absent and behaviour is otherwise identical.

## Test plan
- Reset release with default parameters -> stall_IF/flush/bubble high for exactly 4 cycles, then state_dbg=1 and all controls 0.
- isLd_ALU=1, isWb_ALU=1, rd_ALU=5, rs2_OF=5, use_rs2_OF=1 -> one cycle of stall_IF=stall_IFOF=bubble_OFALU=1. The same case with use_rs2_OF=0 -> no stall.
- isBranchTaken=1 together with a lu match -> pc_sel_branch=1, flush_IFOF=1, bubble_OFALU=1, stall_IF=0.
- isHalt_OF=1 in RUN -> 3 DRAIN cycles, then halted=1. Then step_req 0→1 -> state_dbg=4 for one cycle, then back to 3. Then resume=1 -> RUN with flush_IFOF=1 for one cycle.
- rst pulsed during DRAIN -> next cycle state_dbg=0 and the full 4-cycle flush restarts.
- With PIPE_CTRL_PERF_EN: 3 load-use events and 2 branches -> stall_cnt=3, flush_cnt=2. Forcing 0xFFFF plus one more event -> stall_cnt stays 0xFFFF.
